// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: shared RV encoding constants, one-hot class indices and encoder FSM state type.
package rv_isa_pkg;
    localparam int T_JAL  = 22;
    localparam int T_JALR = 21;
    localparam int T_BEQ  = 20;
    localparam int T_BNE  = 19;
    localparam int T_LD   = 18;
    localparam int T_SD   = 17;
    localparam int T_ADDI = 16;
    localparam int T_SLTI = 15;
    localparam int T_XORI = 14;
    localparam int T_ORI  = 13;
    localparam int T_ANDI = 12;
    localparam int T_SLLI = 11;
    localparam int T_SRLI = 10;
    localparam int T_SRAI = 9;
    localparam int T_ADD  = 8;
    localparam int T_SUB  = 7;
    localparam int T_SLL  = 6;
    localparam int T_SLT  = 5;
    localparam int T_XOR  = 4;
    localparam int T_SRL  = 3;
    localparam int T_SRA  = 2;
    localparam int T_OR   = 1;
    localparam int T_AND  = 0;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_LDS = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0]  F7_ALT = 7'b0100000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN} enc_state_t;

    function automatic logic onehot23(input logic [22:0] t);
        return (t != 23'd0) && ((t & (t - 23'd1)) == 23'd0);
    endfunction
endpackage

// File: rtl/rv_inst_pack.sv
// rv_inst_pack: combinational packing of class + fields into a 32-bit RV word.
//   in_type  one-hot class, rd/rs1/rs2 register indices, imm signed immediate
//   word     encoded instruction (NOP when bad), bad = illegal class or out-of-range imm
//   IMM_RANGE_CHECK_EN enables immediate range checking; otherwise imm is truncated.
module rv_inst_pack
    import rv_isa_pkg::*;
(
    input  logic [22:0] in_type,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        bad
);
    logic is_r, is_i, is_sh, is_b, is_j, is_sd, range_err;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] raw;

    assign is_r  = |in_type[T_ADD:T_AND];
    assign is_i  = |in_type[T_ADDI:T_ANDI];
    assign is_sh = |in_type[T_SLLI:T_SRAI];
    assign is_b  = in_type[T_BEQ] | in_type[T_BNE];
    assign is_j  = in_type[T_JAL];
    assign is_sd = in_type[T_SD];

    assign op = is_r ? OP_R : (is_i | is_sh) ? OP_IALU : in_type[T_LD] ? OP_LD :
                is_sd ? OP_SD : is_b ? OP_B : is_j ? OP_JAL : OP_JALR;

    assign f3 = (in_type[T_SLL] | in_type[T_SLLI] | in_type[T_BNE]) ? F3_SLL :
                (in_type[T_SLT] | in_type[T_SLTI]) ? F3_SLT :
                (in_type[T_LD] | is_sd) ? F3_LDS :
                (in_type[T_XOR] | in_type[T_XORI]) ? F3_XOR :
                (in_type[T_SRL] | in_type[T_SRA] | in_type[T_SRLI] | in_type[T_SRAI]) ? F3_SR :
                (in_type[T_OR] | in_type[T_ORI]) ? F3_OR :
                (in_type[T_AND] | in_type[T_ANDI]) ? F3_AND : F3_ADD;

    assign f7 = (in_type[T_SUB] | in_type[T_SRA] | in_type[T_SRAI]) ? F7_ALT : 7'd0;

    // ADDI..ANDI, LD and JALR all share the plain I layout (the final fallback).
    assign raw = is_r  ? {f7, rs2, rs1, f3, rd, op} :
                 is_sh ? {f7, imm[4:0], rs1, f3, rd, op} :
                 is_sd ? {imm[11:5], rs2, rs1, f3, imm[4:0], op} :
                 is_b  ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op} :
                 is_j  ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, op} :
                         {imm[11:0], rs1, f3, rd, op};

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm;
    assign range_err = is_r  ? 1'b0 :
                       is_sh ? (simm < 0 || simm > 31) :
                       is_b  ? (simm < -4096 || simm > 4094 || imm[0]) :
                       is_j  ? (simm < -1048576 || simm > 1048574 || imm[0]) :
                               (simm < -2048 || simm > 2047);
`else
    logic unused_imm;
    assign unused_imm = ^imm[31:21];
    assign range_err  = 1'b0;
`endif

    assign bad  = ~onehot23(in_type) | range_err;
    assign word = bad ? NOP : raw;
endmodule

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: loads encoded RV instructions into instruction memory at sequential word addresses.
//   start                pulse, begins a load from BASE_WADDR (IDLE only)
//   in_valid/in_ready    field handshake; in_type/in_rd/in_rs1/in_rs2/in_imm/in_last
//   mem_wen_I/waddr/wdata registered write port held until mem_wready
//   done                 one-cycle pulse after the final write; err sticky, cleared by start
//   IMM_RANGE_CHECK_EN (in rv_inst_pack) turns out-of-range immediates into NOP + err.
module rv_inst_encoder
    import rv_isa_pkg::*;
#(
    parameter logic [29:0] BASE_WADDR = 30'd0,
    parameter int          MAX_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [22:0] in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        mem_wen_I,
    output logic [29:0] mem_waddr_I,
    output logic [31:0] mem_wdata_I,
    input  logic        mem_wready,
    output logic        done,
    output logic        err
);
    enc_state_t state, state_nx;
    logic [31:0] word, cnt, idx;
    logic bad, hs, acc, wlast, cap_last;

    rv_inst_pack u_pack (
        .in_type (in_type),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (word),
        .bad     (bad)
    );

    assign acc = mem_wen_I & mem_wready;
    // Once the final word is registered nothing more may enter until it drains.
    assign in_ready = (state == S_LOAD) & (~mem_wen_I | (mem_wready & ~wlast));
    assign hs = in_valid & in_ready;
    // Index of the word being captured, counting a write retiring this same cycle.
    assign idx = cnt + {31'd0, acc};
    assign cap_last = in_last | (idx == 32'(MAX_WORDS - 1));
    assign done = (state == S_FIN);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = (acc & wlast) ? S_FIN : S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mem_wen_I   <= 1'b0;
            mem_waddr_I <= BASE_WADDR;
            mem_wdata_I <= 32'd0;
            wlast       <= 1'b0;
            cnt         <= 32'd0;
            err         <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                mem_waddr_I <= BASE_WADDR;
                cnt         <= 32'd0;
                err         <= 1'b0;
                wlast       <= 1'b0;
            end
            if (acc) begin
                mem_waddr_I <= mem_waddr_I + 30'd1;
                cnt         <= cnt + 32'd1;
            end
            if (hs) begin
                mem_wen_I   <= 1'b1;
                mem_wdata_I <= word;
                wlast       <= cap_last;
                if (bad | (cap_last & ~in_last))
                    err <= 1'b1;
            end else if (acc) begin
                mem_wen_I <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv_inst_encoder.sv
// tb_rv_inst_encoder: directed stimulus with a spec-level model checked every cycle.
module tb_rv_inst_encoder;
    localparam logic [29:0] BASE = 30'd0;
    localparam int MAXW = 4;

    localparam logic [22:0] TY_JAL  = 23'd1 << 22;
    localparam logic [22:0] TY_BEQ  = 23'd1 << 20;
    localparam logic [22:0] TY_SD   = 23'd1 << 17;
    localparam logic [22:0] TY_ADDI = 23'd1 << 16;
    localparam logic [22:0] TY_XORI = 23'd1 << 14;
    localparam logic [22:0] TY_ADD  = 23'd1 << 8;
    localparam logic [22:0] TY_SUB  = 23'd1 << 7;

    logic clk = 0, rst_n, start, in_valid, in_ready, in_last, mem_wen_I, mem_wready, done, err;
    logic [22:0] in_type;
    logic [4:0] in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, mem_wdata_I;
    logic [29:0] mem_waddr_I;

    int errors = 0, checks = 0, cyc = 0;

    typedef struct { logic [31:0] d; bit last; } exp_t;
    typedef struct { logic [29:0] a; logic [31:0] d; int c; } wr_t;
    exp_t q[$];
    wr_t wlog[$];
    logic [29:0] addr_m = BASE;
    int cnt_m = 0, ph = 0;
    bit err_m = 0, done_m = 0;

    rv_inst_encoder #(.BASE_WADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_wen_I(mem_wen_I), .mem_waddr_I(mem_waddr_I),
        .mem_wdata_I(mem_wdata_I), .mem_wready(mem_wready), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Encoding straight from the ISA field tables: format, opcode, funct3, funct7 per class.
    function automatic void enc_m(input logic [22:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  output logic [31:0] w, output bit bad);
        int k = 0, n = 0, fmt = 1, s;
        logic [31:0] op = 0, f3 = 0, f7 = 0, ui;
        for (int i = 0; i < 23; i++) if (t[i]) begin n++; k = i; end
        bad = (n != 1);
        case (k)
            22: begin fmt = 5; op = 'h6F; end
            21: begin fmt = 1; op = 'h67; end
            20: begin fmt = 4; op = 'h63; end
            19: begin fmt = 4; op = 'h63; f3 = 1; end
            18: begin fmt = 1; op = 'h03; f3 = 3; end
            17: begin fmt = 3; op = 'h23; f3 = 3; end
            16: begin fmt = 1; op = 'h13; end
            15: begin fmt = 1; op = 'h13; f3 = 2; end
            14: begin fmt = 1; op = 'h13; f3 = 4; end
            13: begin fmt = 1; op = 'h13; f3 = 6; end
            12: begin fmt = 1; op = 'h13; f3 = 7; end
            11: begin fmt = 2; op = 'h13; f3 = 1; end
            10: begin fmt = 2; op = 'h13; f3 = 5; end
            9:  begin fmt = 2; op = 'h13; f3 = 5; f7 = 32; end
            8:  begin fmt = 0; op = 'h33; end
            7:  begin fmt = 0; op = 'h33; f7 = 32; end
            6:  begin fmt = 0; op = 'h33; f3 = 1; end
            5:  begin fmt = 0; op = 'h33; f3 = 2; end
            4:  begin fmt = 0; op = 'h33; f3 = 4; end
            3:  begin fmt = 0; op = 'h33; f3 = 5; end
            2:  begin fmt = 0; op = 'h33; f3 = 5; f7 = 32; end
            1:  begin fmt = 0; op = 'h33; f3 = 6; end
            default: begin fmt = 0; op = 'h33; f3 = 7; end
        endcase
        ui = imm;
        s = $signed(imm);
        case (fmt)
            0: w = f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + op;
            1: w = (ui % 4096) * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + op;
            2: w = f7 * (1 << 25) + (ui % 32) * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + op;
            3: w = ((ui / 32) % 128) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
                   + (ui % 32) * (1 << 7) + op;
            4: w = ((ui / 4096) % 2) * (1 << 31) + ((ui / 32) % 64) * (1 << 25) + rs2 * (1 << 20)
                   + rs1 * (1 << 15) + f3 * (1 << 12) + ((ui / 2) % 16) * (1 << 8) + ((ui / 2048) % 2) * (1 << 7) + op;
            default: w = ((ui / (1 << 20)) % 2) * (1 << 31) + ((ui / 2) % 1024) * (1 << 21)
                   + ((ui / 2048) % 2) * (1 << 20) + ((ui / 4096) % 256) * (1 << 12) + rd * (1 << 7) + op;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        if (fmt == 1 || fmt == 3) bad = bad || s < -2048 || s > 2047;
        if (fmt == 2) bad = bad || s < 0 || s > 31;
        if (fmt == 4) bad = bad || s < -4096 || s > 4094 || (ui % 2) != 0;
        if (fmt == 5) bad = bad || s < -1048576 || s > 1048574 || (ui % 2) != 0;
`endif
        if (bad) w = 32'h0000_0013;
    endfunction

    // Compare process: outputs are checked at every falling edge, then the model advances
    // to predict the state after the following rising edge.
    always @(negedge clk) begin
        logic [31:0] w;
        bit b, rdy;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete(); addr_m = BASE; cnt_m = 0; err_m = 0; done_m = 0; ph = 0;
        end else begin
            chk("done", {31'd0, done}, {31'd0, done_m});
            chk("err", {31'd0, err}, {31'd0, err_m});
            if (mem_wen_I) begin
                if (q.size() == 0) chk("unexpected write", 32'd1, 32'd0);
                else begin
                    chk("waddr", {2'b0, mem_waddr_I}, {2'b0, addr_m});
                    chk("wdata", mem_wdata_I, q[0].d);
                end
            end else chk("pending writes lost", q.size(), 0);
            rdy = (ph == 1) && (!mem_wen_I || (mem_wready && !(q.size() > 0 && q[0].last)));
            chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
            done_m = 0;
            if (ph == 2) ph = 0;
            else if (ph == 0 && start) begin ph = 1; err_m = 0; addr_m = BASE; cnt_m = 0; end
            if (mem_wen_I && mem_wready && q.size() > 0) begin
                e = q.pop_front();
                wlog.push_back('{a: mem_waddr_I, d: mem_wdata_I, c: cyc});
                addr_m = addr_m + 1; cnt_m++;
                if (e.last) begin done_m = 1; ph = 2; end
            end
            if (in_valid && in_ready) begin
                enc_m(in_type, in_rd, in_rs1, in_rs2, in_imm, w, b);
                e.d = w;
                e.last = in_last || (cnt_m == MAXW - 1);
                if (b || (cnt_m == MAXW - 1 && !in_last)) err_m = 1;
                q.push_back(e);
            end
        end
    end

    task automatic do_start();
        wlog.delete();
        start = 1;
        @(posedge clk); #2;
        start = 0;
    endtask

    task automatic send(input logic [22:0] t, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] im, input logic lst);
        int n = 0;
        in_type = t; in_rd = rd; in_rs1 = r1; in_rs2 = r2; in_imm = im; in_last = lst; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (!in_ready) chk("handshake timeout", 32'd1, 32'd0);
        @(posedge clk); #2;
        in_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 100) begin n++; @(negedge clk); end
        chk("done seen", {31'd0, done}, 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic chk_wr(input string nm, input int i, input logic [29:0] a, input logic [31:0] d);
        if (wlog.size() <= i) chk({nm, " missing"}, wlog.size(), i + 1);
        else begin
            chk({nm, " addr"}, {2'b0, wlog[i].a}, {2'b0, a});
            chk({nm, " data"}, wlog[i].d, d);
        end
    endtask

    initial begin
        logic [31:0] w;
        bit b;
        rst_n = 0; start = 0; in_valid = 0; in_last = 0; mem_wready = 1;
        in_type = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;

        enc_m(TY_ADDI, 1, 0, 0, 5, w, b);          chk("model addi", w, 32'h0050_0093);
        enc_m(TY_BEQ, 0, 1, 2, -4, w, b);          chk("model beq", w, 32'hFE20_8EE3);
        enc_m(TY_JAL, 1, 0, 0, 8, w, b);           chk("model jal", w, 32'h0080_00EF);

        repeat (2) @(posedge clk);
        #1;
        chk("rst wen", {31'd0, mem_wen_I}, 0);
        chk("rst waddr", {2'b0, mem_waddr_I}, {2'b0, BASE});
        chk("rst wdata", mem_wdata_I, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst err", {31'd0, err}, 0);
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); #2;

        do_start();
        send(TY_ADDI, 1, 0, 0, 5, 1);
        wait_done();
        chk_wr("addi", 0, BASE, 32'h0050_0093);

        do_start();
        send(TY_ADD, 3, 1, 2, 0, 0);
        send(TY_SUB, 3, 1, 2, 0, 1);
        wait_done();
        chk_wr("add", 0, BASE, 32'h0020_81B3);
        chk_wr("sub", 1, BASE + 1, 32'h4020_81B3);
        if (wlog.size() == 2) chk("back-to-back", wlog[1].c - wlog[0].c, 1);

        do_start();
        send(TY_BEQ, 0, 1, 2, -4, 0);
        send(TY_JAL, 1, 0, 0, 8, 0);
        send(TY_SD, 0, 1, 2, 8, 1);
        wait_done();
        chk_wr("beq", 0, BASE, 32'hFE20_8EE3);
        chk_wr("jal", 1, BASE + 1, 32'h0080_00EF);
        chk_wr("sd", 2, BASE + 2, 32'h0020_B423);

        do_start();
        mem_wready = 0;
        send(TY_ADDI, 2, 0, 0, 7, 0);
        in_type = TY_XORI; in_rd = 3; in_rs1 = 2; in_rs2 = 0; in_imm = 1; in_last = 1; in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stall in_ready", {31'd0, in_ready}, 0);
            chk("stall wen", {31'd0, mem_wen_I}, 1);
            chk("stall waddr", {2'b0, mem_waddr_I}, {2'b0, BASE});
            chk("stall wdata", mem_wdata_I, 32'h0070_0113);
        end
        @(posedge clk); #2;
        mem_wready = 1;
        send(TY_XORI, 3, 2, 0, 1, 1);
        wait_done();
        chk_wr("stalled addi", 0, BASE, 32'h0070_0113);
        chk_wr("xori", 1, BASE + 1, 32'h0011_4193);

        do_start();
        send(23'h000003, 1, 2, 3, 0, 0);
`ifdef IMM_RANGE_CHECK_EN
        send(TY_ADDI, 1, 0, 0, 5, 0);
        send(TY_ADDI, 1, 0, 0, 4096, 1);
`else
        send(TY_ADDI, 1, 0, 0, 5, 1);
`endif
        wait_done();
        chk_wr("illegal nop", 0, BASE, 32'h0000_0013);
        chk_wr("after illegal", 1, BASE + 1, 32'h0050_0093);
`ifdef IMM_RANGE_CHECK_EN
        chk_wr("range nop", 2, BASE + 2, 32'h0000_0013);
`endif
        repeat (3) begin
            @(negedge clk);
            chk("err sticky", {31'd0, err}, 1);
        end
        @(posedge clk); #2;
        do_start();
        @(negedge clk);
        chk("err cleared", {31'd0, err}, 0);
        @(posedge clk); #2;
        send(TY_ADDI, 1, 0, 0, 5, 1);
        wait_done();

        do_start();
        for (int i = 0; i < MAXW; i++) send(TY_ADDI, 5'(i), 0, 0, i, 0);
        wait_done();
        chk("overflow err", {31'd0, err}, 1);
        chk("overflow writes", wlog.size(), MAXW);
        chk_wr("overflow last", MAXW - 1, BASE + 3, 32'h0030_0193);

        do_start();
        mem_wready = 0;
        send(TY_ADDI, 1, 0, 0, 5, 0);
        #1 rst_n = 0;
        #1;
        chk("midrst wen", {31'd0, mem_wen_I}, 0);
        chk("midrst waddr", {2'b0, mem_waddr_I}, {2'b0, BASE});
        chk("midrst wdata", mem_wdata_I, 0);
        chk("midrst in_ready", {31'd0, in_ready}, 0);
        mem_wready = 1;
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); #2;
        do_start();
        send(TY_ADDI, 5, 0, 0, -1, 1);
        wait_done();
        chk_wr("post reset", 0, BASE, 32'hFFF0_0293);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
